// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI frame buffer.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an async pin plus rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d_in};
    prev_d = sync_q[N-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[N-1] & ~prev_q;
  assign fall = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_frame_buffer.sv
// Oversampled mode-0 SPI slave that gathers words into a frame buffer
// and reloads its MISO word through a tx_word/tx_next handshake.
module spi_frame_buffer
  import spi_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   spi_sclk,
  input  logic                   spi_cs_n,
  input  logic                   spi_rx,
  output logic                   spi_tx,
  input  logic [CW-1:0]          length,
  input  logic [WIDTH-1:0]       tx_word,
  output logic                   tx_next,
  output logic [DEPTH*WIDTH-1:0] rx_flat,
  output logic [CW-1:0]          count,
  output logic                   valid,
  output logic                   overflow,
  output logic                   frame_start,
  output logic                   frame_end
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk (
    .clk    (clk),
    .reset_n(reset_n),
    .d_in   (spi_sclk),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk    (clk),
    .reset_n(reset_n),
    .d_in   (spi_cs_n),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  // rx runs through the same depth so it lines up with the sclk strobe
  logic [NS-1:0] rx_sync_q, rx_sync_d;
  logic          rx_s;

  assign rx_sync_d = {rx_sync_q[NS-2:0], spi_rx};
  assign rx_s      = rx_sync_q[NS-1];

  spi_state_e             state_q, state_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [WIDTH-2:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DEPTH*WIDTH-1:0] flat_q, flat_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic                   tx_next_q, tx_next_d;
  logic                   fs_q, fs_d;
  logic                   fe_q, fe_d;
  logic                   spi_tx_q, spi_tx_d;
  logic [WIDTH-1:0]       rx_word;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    count_d    = count_q;
    flat_d     = flat_q;
    ovf_d      = ovf_q;
    done_d     = done_q;
    tx_next_d  = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    rx_word    = {rx_shift_q, rx_s};

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          fs_d       = 1'b1;
          tx_next_d  = 1'b1;
          count_d    = '0;
          bit_d      = '0;
          ovf_d      = 1'b0;
          done_d     = 1'b0;
          tx_shift_d = tx_word;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          fe_d    = 1'b1;
          bit_d   = '0;
          done_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_word[WIDTH-2:0];
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d  = '0;
            done_d = 1'b1;
            if (count_q < CW'(DEPTH)) begin
              for (int i = 0; i < DEPTH; i++) begin
                if (count_q == CW'(i)) begin
                  flat_d[i*WIDTH +: WIDTH] = rx_word;
                end
              end
              count_d = count_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (done_q) begin
            tx_shift_d = tx_word;
            tx_next_d  = 1'b1;
            done_d     = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    spi_tx_d = tx_shift_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sync_q  <= '0;
      state_q    <= IDLE;
      bit_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      count_q    <= '0;
      flat_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      tx_next_q  <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      spi_tx_q   <= 1'b0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      state_q    <= state_d;
      bit_q      <= bit_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      count_q    <= count_d;
      flat_q     <= flat_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      tx_next_q  <= tx_next_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      spi_tx_q   <= spi_tx_d;
    end
  end

  assign spi_tx      = spi_tx_q;
  assign tx_next     = tx_next_q;
  assign rx_flat     = flat_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign valid       = (count_q == length) && (length != '0);

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed bench for spi_frame_buffer with a word-level frame model
// checked every cycle plus hand-computed expectations.
module tb_spi_frame_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_rx = 1'b0;
  logic [CW-1:0] length = 3'd3;
  logic [WIDTH-1:0] tx_word = 8'h00;
  logic spi_tx, tx_next, valid, overflow;
  logic frame_start, frame_end;
  logic [CW-1:0] count;
  logic [DEPTH*WIDTH-1:0] rx_flat;

  spi_frame_buffer #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_rx     (spi_rx),
    .spi_tx     (spi_tx),
    .length     (length),
    .tx_word    (tx_word),
    .tx_next    (tx_next),
    .rx_flat    (rx_flat),
    .count      (count),
    .valid      (valid),
    .overflow   (overflow),
    .frame_start(frame_start),
    .frame_end  (frame_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_count = 0;
  bit exp_ovf = 0;
  logic [7:0] mem [DEPTH];
  bit reload = 0;
  bit chk_en = 0;
  int exp_fs = 0, exp_fe = 0, exp_txn = 0;
  int fs_seen = 0, fe_seen = 0, txn_seen = 0;
  logic [7:0] miso = 8'h00;
  logic [7:0] txq [$];
  logic [DEPTH*WIDTH-1:0] ef;
  logic ev;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (frame_start) fs_seen++;
      if (frame_end) fe_seen++;
      if (tx_next) txn_seen++;
      if (chk_en) begin
        for (int i = 0; i < DEPTH; i++) ef[i*8 +: 8] = mem[i];
        ev = (exp_count == int'(length)) && (length != '0);
        check("count", 64'(count), 64'(exp_count));
        check("valid", 64'(valid), 64'(ev));
        check("overflow", 64'(overflow), 64'(exp_ovf));
        check("rx_flat", 64'(rx_flat), 64'(ef));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      if (tx_next) begin
        if (txq.size() > 0) tx_word = txq.pop_front();
        else tx_word = 8'h00;
      end
    end
  endtask

  task automatic m_commit(logic [7:0] w);
    if (exp_count < DEPTH) begin
      mem[exp_count] = w;
      exp_count++;
    end else begin
      exp_ovf = 1'b1;
    end
    reload = 1'b1;
  endtask

  task automatic m_clear();
    exp_count = 0;
    exp_ovf = 1'b0;
    reload = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  task automatic begin_frame();
    spi_cs_n = 1'b0;
    step(SYNC);
    exp_count = 0;
    exp_ovf = 1'b0;
    reload = 1'b0;
    exp_fs++;
    exp_txn++;
    step(4);
  endtask

  task automatic end_frame();
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    reload = 1'b0;
    step(SYNC);
    exp_fe++;
    step(4);
  endtask

  task automatic send_word(logic [7:0] w, int n);
    for (int b = 0; b < n; b++) begin
      if (spi_sclk) begin
        spi_sclk = 1'b0;
        if (reload) begin
          exp_txn++;
          reload = 1'b0;
        end
      end
      spi_rx = w[7-b];
      step(4);
      spi_sclk = 1'b1;
      miso = {miso[6:0], spi_tx};
      if (b == 7) begin
        step(SYNC);
        m_commit(w);
        step(4 - SYNC);
      end else begin
        step(4);
      end
    end
  endtask

  task automatic check_pulses();
    check("frame_start pulses", 64'(fs_seen), 64'(exp_fs));
    check("frame_end pulses", 64'(fe_seen), 64'(exp_fe));
    check("tx_next pulses", 64'(txn_seen), 64'(exp_txn));
  endtask

  int txn0, fe0;

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    step(3);
    check("rst count", 64'(count), 64'd0);
    check("rst valid", 64'(valid), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst spi_tx", 64'(spi_tx), 64'd0);
    check("rst rx_flat", 64'(rx_flat), 64'd0);
    check("rst tx_next", 64'(tx_next), 64'd0);
    check("rst frame_start", 64'(frame_start), 64'd0);
    check("rst frame_end", 64'(frame_end), 64'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    step(2);

    begin_frame();
    send_word(8'hA5, 8);
    send_word(8'h3C, 8);
    send_word(8'hFF, 8);
    end_frame();
    check("t1 count", 64'(count), 64'd3);
    check("t1 valid", 64'(valid), 64'd1);
    check("t1 rx_flat", 64'(rx_flat[23:0]), 64'hFF3CA5);
    check("t1 overflow", 64'(overflow), 64'd0);
    check("t1 frame_start", 64'(fs_seen), 64'd1);
    check("t1 frame_end", 64'(fe_seen), 64'd1);
    check_pulses();

    tx_word = 8'h81;
    txq.push_back(8'h42);
    txq.push_back(8'h24);
    txn0 = txn_seen;
    begin_frame();
    send_word(8'h10, 8);
    check("t2 miso0", 64'(miso), 64'h81);
    send_word(8'h20, 8);
    check("t2 miso1", 64'(miso), 64'h42);
    send_word(8'h30, 8);
    check("t2 miso2", 64'(miso), 64'h24);
    end_frame();
    check("t2 tx_next count", 64'(txn_seen - txn0), 64'd3);
    check("t2 rx_flat", 64'(rx_flat), 64'h00302010);
    check_pulses();

    length = 3'd4;
    begin_frame();
    for (int k = 1; k <= 5; k++) send_word(8'(k), 8);
    end_frame();
    check("t3 count", 64'(count), 64'd4);
    check("t3 valid", 64'(valid), 64'd1);
    check("t3 overflow", 64'(overflow), 64'd1);
    check("t3 rx_flat", 64'(rx_flat), 64'h04030201);
    begin_frame();
    check("t3 clr count", 64'(count), 64'd0);
    check("t3 clr overflow", 64'(overflow), 64'd0);
    check("t3 keep rx_flat", 64'(rx_flat), 64'h04030201);

    send_word(8'h11, 8);
    send_word(8'hE0, 3);
    end_frame();
    check("t4 count", 64'(count), 64'd1);
    check("t4 rx_flat", 64'(rx_flat), 64'h04030211);
    length = 3'd1;
    begin_frame();
    send_word(8'h22, 8);
    end_frame();
    check("t4 next word", 64'(rx_flat), 64'h04030222);
    check("t4 valid", 64'(valid), 64'd1);
    check_pulses();

    length = 3'd0;
    begin_frame();
    send_word(8'h55, 8);
    send_word(8'h66, 8);
    end_frame();
    check("t5a count", 64'(count), 64'd2);
    check("t5a valid", 64'(valid), 64'd0);

    length = 3'd5;
    begin_frame();
    for (int k = 0; k < 5; k++) send_word(8'(8'h71 + k), 8);
    end_frame();
    check("t5b count", 64'(count), 64'd4);
    check("t5b valid", 64'(valid), 64'd0);
    check("t5b overflow", 64'(overflow), 64'd1);

    length = 3'd2;
    begin_frame();
    send_word(8'h81, 8);
    send_word(8'h82, 8);
    send_word(8'h83, 8);
    end_frame();
    check("t5c count", 64'(count), 64'd3);
    check("t5c valid len2", 64'(valid), 64'd0);
    length = 3'd3;
    #1;
    check("t5c valid len3", 64'(valid), 64'd1);
    check_pulses();

    step(1);
    length = 3'd2;
    tx_word = 8'hFF;
    repeat (4) txq.push_back(8'hFF);
    begin_frame();
    send_word(8'h33, 8);
    send_word(8'h44, 8);
    send_word(8'hC0, 3);
    check("t6 pre valid", 64'(valid), 64'd1);
    check("t6 pre spi_tx", 64'(spi_tx), 64'd1);
    fe0 = fe_seen;
    reset_n = 1'b0;
    m_clear();
    @(posedge clk);
    #1;
    check("t6 count", 64'(count), 64'd0);
    check("t6 valid", 64'(valid), 64'd0);
    check("t6 spi_tx", 64'(spi_tx), 64'd0);
    txq.delete();
    step(1);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(4);
    check("t6 no frame_end", 64'(fe_seen), 64'(fe0));
    length = 3'd1;
    begin_frame();
    send_word(8'h5A, 8);
    end_frame();
    check("t6 rx_flat", 64'(rx_flat), 64'h0000005A);
    check("t6 count after", 64'(count), 64'd1);
    check("t6 valid after", 64'(valid), 64'd1);
    check_pulses();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
